// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side transmitter: start, 8 data bits LSB first, odd parity, stop on ps2_clk/ps2_data.
// Latency: frame starts the cycle after acceptance (one cycle later with `define PS2_TX_FIFO_EN); 22*HALF_PERIOD cycles + GAP_CYCLES gap.
// Backpressure: tx_ready low while a frame is in flight, or while the input FIFO is full when PS2_TX_FIFO_EN is defined.

`ifdef PS2_TX_FIFO_EN
// Generic single-clock FIFO: registered occupancy, head visible on rd_dat.
// Latency: a pushed entry is visible on rd_dat the following cycle.
// Backpressure: wr_rdy low when full; simultaneous push and pop are both honoured.
module ps2_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    assign wr_rdy = (count != CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule
`endif

module ps2_keyboard_tx #(
    parameter int HALF_PERIOD = 8,
    parameter int GAP_CYCLES  = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       frame_done
);
    localparam int PW = $clog2(HALF_PERIOD + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW-1:0] PH_LOAD  = PW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic [10:0]   sh, sh_nxt;
    logic          src_vld;
    logic [7:0]    src_dat;
    logic          clk_nxt, data_nxt, done_nxt;

`ifdef PS2_TX_FIFO_EN
    logic fifo_vld;

    ps2_tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (tx_valid),
        .wr_dat (tx_data),
        .wr_rdy (tx_ready),
        .rd_vld (fifo_vld),
        .rd_dat (src_dat),
        .rd_rdy (state == IDLE)
    );
    assign src_vld = fifo_vld;
    assign busy    = (state != IDLE) || fifo_vld;
`else
    // FIFO_DEPTH only sizes the optional input queue
    logic [$clog2(FIFO_DEPTH + 1)-1:0] unused_depth;
    assign unused_depth = '0;
    assign src_vld  = tx_valid;
    assign src_dat  = tx_data;
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            sh         <= '1;
            ps2_clk    <= 1'b1;
            ps2_data   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            gap_cnt    <= gap_nxt;
            bit_cnt    <= bit_nxt;
            sh         <= sh_nxt;
            ps2_clk    <= clk_nxt;
            ps2_data   <= data_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        gap_nxt   = gap_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = sh;
        unique case (state)
            IDLE: begin
                if (src_vld) begin
                    sh_nxt    = {1'b1, ~^src_dat, src_dat, 1'b0};
                    bit_nxt   = '0;
                    phase_nxt = PH_LOAD;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (phase == '0) begin
                    phase_nxt = PH_LOAD;
                    state_nxt = LOW;
                end else begin
                    phase_nxt = phase - 1'b1;
                end
            end
            LOW: begin
                if (phase != '0) begin
                    phase_nxt = phase - 1'b1;
                end else if (bit_cnt == 4'd10) begin
                    gap_nxt   = GAP_LOAD;
                    state_nxt = GAP;
                end else begin
                    bit_nxt   = bit_cnt + 4'd1;
                    phase_nxt = PH_LOAD;
                    state_nxt = HIGH;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
                else               gap_nxt   = gap_cnt - 1'b1;
            end
        endcase
    end

    // Line values are derived from the next state so both pins come straight off flops.
    always_comb begin
        clk_nxt  = (state_nxt != LOW);
        data_nxt = 1'b1;
        if (state_nxt == HIGH || state_nxt == LOW) begin
            data_nxt = sh_nxt[bit_nxt];
        end
        done_nxt = (state == LOW) && (state_nxt == GAP);
    end
endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: scoreboard of expected frames checked by a PS/2 host-side receiver model.
// Covers reset, frame contents, timing, mid-frame reset, backpressure, and the optional input FIFO.
module tb_ps2_keyboard_tx;
    localparam int HP  = 4;
    localparam int GAP = 8;
`ifdef PS2_TX_FIFO_EN
    localparam int LAT = 22 * HP + 1;
`else
    localparam int LAT = 22 * HP;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk, ps2_data, busy, frame_done;

    ps2_keyboard_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    logic [10:0] sb[$];

    // Host-side receiver: samples ps2_data on each ps2_clk falling edge.
    logic        prev_clk = 1'b1;
    int          rx_nb = 0;
    int          rx_cnt = 0;
    logic [10:0] rx_sh = '0;
    logic [10:0] rx_last = '0;
    always @(negedge clk) begin
        if (rst) begin
            rx_nb    = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk) begin
                rx_sh[rx_nb] = ps2_data;
                rx_nb++;
                if (rx_nb == 11) begin
                    chk("rx_start", rx_sh[0], 0);
                    chk("rx_stop", rx_sh[10], 1);
                    chk("rx_parity_odd", ^rx_sh[9:1], 1);
                    chk("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) chk("rx_frame", rx_sh, sb.pop_front());
                    rx_last = rx_sh;
                    rx_cnt++;
                    rx_nb = 0;
                end
            end
            prev_clk = ps2_clk;
        end
    end

    task automatic send(input logic [7:0] b, output int t_acc);
        bit acc = 0;
        @(posedge clk); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = tx_ready;
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        t_acc = cyc;
        chk("send_accept", acc, 1);
        if (acc) sb.push_back(mk_frame(b));
    endtask

    task automatic wait_done(output int t);
        bit ok = 0;
        t = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1;
                t = cyc;
            end
        end
        chk("frame_done_seen", ok, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        int t0, t1, g, acc, base;
        int td[5];
        #200_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t0, t1, g, acc, base;
        int td[5];
        repeat (2) @(negedge clk);
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_data", ps2_data, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_tx_ready", tx_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // 0x1C: bit pattern, latency, pulse width and gap length
        send(8'h1C, t0);
        wait_done(t1);
        chk("latency_1c", t1 - t0, LAT);
        chk("frame_1c_bits", rx_last, 11'h438);
        chk("edges_left", rx_nb, 0);
        @(negedge clk);
        chk("done_pulse_width", frame_done, 0);
        chk("gap_lines_high", ps2_clk & ps2_data, 1);
        g = 1;
        for (int i = 0; i < 50 && busy; i++) begin
            g++;
            @(negedge clk);
        end
        chk("gap_cycles", g, GAP);

        // 0xF0: parity bit set
        send(8'hF0, t0);
        wait_done(t1);
        chk("frame_f0_bits", rx_last, 11'h7E0);
        chk("rx_f0_byte", rx_last[8:1], 8'hF0);

        // Make / release / make loopback
        base = rx_cnt;
        send(8'h1C, t0);
        send(8'hF0, t0);
        send(8'h1C, t0);
        for (int i = 0; i < 2000 && rx_cnt < base + 3; i++) @(negedge clk);
        chk("loopback_frames", rx_cnt - base, 3);
        chk("loopback_last", rx_last[8:1], 8'h1C);
        wait_idle();

        // Reset during data bit 5 (0x55 has bit 5 = 0, so both lines are low there)
        send(8'h55, t0);
        for (int i = 0; i < 400 && rx_nb != 7; i++) @(negedge clk);
        chk("rst_point_reached", rx_nb, 7);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ps2_clk", ps2_clk, 1);
        chk("midrst_ps2_data", ps2_data, 1);
        sb.delete();
        @(negedge clk);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h2A, t0);
        wait_done(t1);
        chk("latency_2a", t1 - t0, LAT);
        chk("rx_2a_byte", rx_last[8:1], 8'h2A);
        wait_idle();

`ifdef PS2_TX_FIFO_EN
        // Consecutive pushes; the sixth meets a full FIFO
        begin
            logic [7:0] bytes [6];
            bit         exp_rdy [6];
            bytes   = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
            exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            t0 = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (k == 1) t0 = cyc;
                tx_data  = bytes[k];
                tx_valid = 1'b1;
                @(negedge clk);
                chk("fifo_tx_ready", tx_ready, exp_rdy[k]);
                if (tx_ready) sb.push_back(mk_frame(bytes[k]));
            end
            @(posedge clk); #1;
            tx_valid = 1'b0;
            for (int f = 0; f < 5; f++) wait_done(td[f]);
            chk("fifo_first_latency", td[0] - t0, LAT);
            for (int f = 0; f < 4; f++) chk("fifo_frame_spacing", td[f+1] - td[f], 22 * HP + GAP + 1);
        end
`else
        // tx_valid held through a frame: one acceptance only
        @(posedge clk); #1;
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        sb.push_back(mk_frame(8'h33));
        acc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) acc++;
        end
        chk("hold_ready_low", tx_ready, 0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("hold_accepts", acc, 1);
        wait_done(t1);
`endif
        wait_idle();
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
